// File: rtl/synth_pkg.sv
// Shared types and constants for the audio source voice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package synth_pkg;

    // Waveform selector encoding as seen on wave_sel.
    typedef enum logic [1:0] {
        SAW      = 2'd0,
        TRIANGLE = 2'd1,
        PULSE    = 2'd2,
        SILENCE  = 2'd3
    } wave_t;

    // Envelope phase; exported on env_state for debug and voice allocation.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/adsr_envelope.sv
// Gate-driven ADSR envelope with retrigger from RELEASE at the current level.
// Latency: level/state update 1 mclk after the tick cycle; only ticks step the FSM.
// Backpressure: none; a tick always advances the envelope.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int ENV_BITS = 16
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                tick,
    input  logic                gate,
    input  logic [ENV_BITS-1:0] attack_rate,
    input  logic [ENV_BITS-1:0] decay_rate,
    input  logic [ENV_BITS-1:0] sustain_level,
    input  logic [ENV_BITS-1:0] release_rate,
    output logic [ENV_BITS-1:0] level,
    output adsr_state_t         state
);

    localparam logic [ENV_BITS-1:0] LEVEL_MAX = {ENV_BITS{1'b1}};
    localparam logic [ENV_BITS:0]   LEVEL_MAX_EXT = {1'b0, LEVEL_MAX};

    adsr_state_t         state_nxt;
    logic [ENV_BITS-1:0] level_nxt;
    logic [ENV_BITS:0]   sum_atk;
    logic [ENV_BITS:0]   dif_dec;
    logic [ENV_BITS:0]   dif_rel;

    // One extra bit on every step so saturation is detected instead of wrapping.
    always_comb begin
        sum_atk = {1'b0, level} + {1'b0, attack_rate};
        dif_dec = {1'b0, level} - {1'b0, decay_rate};
        dif_rel = {1'b0, level} - {1'b0, release_rate};
    end

    // Next state / level; a gate change wins over the step on the same tick.
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        if (tick) begin
            case (state)
                IDLE: begin
                    level_nxt = '0;
                    if (gate) state_nxt = ATTACK;
                end
                ATTACK: begin
                    if (!gate) begin
                        state_nxt = RELEASE;
                    end else if (sum_atk >= LEVEL_MAX_EXT) begin
                        level_nxt = LEVEL_MAX;
                        state_nxt = DECAY;
                    end else begin
                        level_nxt = sum_atk[ENV_BITS-1:0];
                    end
                end
                DECAY: begin
                    if (!gate) begin
                        state_nxt = RELEASE;
                    end else if (dif_dec[ENV_BITS] || (dif_dec[ENV_BITS-1:0] <= sustain_level)) begin
                        level_nxt = sustain_level;
                        state_nxt = SUSTAIN;
                    end else begin
                        level_nxt = dif_dec[ENV_BITS-1:0];
                    end
                end
                SUSTAIN: begin
                    if (!gate) state_nxt = RELEASE;
                    else       level_nxt = sustain_level;
                end
                RELEASE: begin
                    if (gate) begin
                        state_nxt = ATTACK;
                    end else if (dif_rel[ENV_BITS] || (dif_rel[ENV_BITS-1:0] == '0)) begin
                        level_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        level_nxt = dif_rel[ENV_BITS-1:0];
                    end
                end
                default: begin
                    level_nxt = '0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Envelope state register.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= IDLE;
            level <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
        end
    end

endmodule

// File: rtl/src_adsr_osc.sv
// Single-voice source: phase-accumulator oscillator, waveform shaper, ADSR and volume scaling.
// Latency: 3 mclk from the pblrc rising-edge tick cycle to valid / p_sample_buffer.
// Backpressure: none; one sample per pblrc rise, valid is a 1-mclk pulse.
module src_adsr_osc
    import synth_pkg::*;
#(
    parameter int PHASE_BITS    = 24,
    parameter int FREQ_RES_BITS = 24,
    parameter int ENV_BITS      = 16,
    parameter int VOLUME_BITS   = 8
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     pblrc,
    input  logic                     gate,
    input  logic [1:0]               wave_sel,
    input  logic [FREQ_RES_BITS-1:0] p_frequency,
    input  logic [7:0]               pulse_width,
    input  logic [ENV_BITS-1:0]      attack_rate,
    input  logic [ENV_BITS-1:0]      decay_rate,
    input  logic [ENV_BITS-1:0]      sustain_level,
    input  logic [ENV_BITS-1:0]      release_rate,
    input  logic [VOLUME_BITS-1:0]   volume,
    output logic signed [15:0]       p_sample_buffer,
    output logic                     valid,
    output logic [2:0]               env_state
);

    localparam int P1W = 16 + ENV_BITS + 1;
    localparam int P2W = 16 + VOLUME_BITS + 1;

    logic                    pblrc_q;
    logic                    tick;
    logic                    stg1_vld;
    logic                    stg2_vld;
    logic [PHASE_BITS-1:0]   phase;
    wave_t                   wave_q1;
    logic [7:0]              pw_q1;
    logic [VOLUME_BITS-1:0]  vol_q1;
    logic [VOLUME_BITS-1:0]  vol_q2;
    logic [ENV_BITS-1:0]     level;
    logic [ENV_BITS-1:0]     level_q2;
    adsr_state_t             state;
    logic [15:0]             p;
    logic [15:0]             tri_t;
    logic signed [15:0]      wave_dat;
    logic signed [15:0]      wave_q2;
    logic signed [P1W-1:0]   prod1;
    logic signed [P1W-1:0]   sh1;
    logic signed [15:0]      s1;
    logic signed [P2W-1:0]   prod2;
    logic signed [P2W-1:0]   sh2;
    logic                    unused_ok;

    assign tick      = pblrc & ~pblrc_q;
    assign env_state = state;

    adsr_envelope #(
        .ENV_BITS(ENV_BITS)
    ) u_env (
        .mclk          (mclk),
        .rst           (rst),
        .tick          (tick),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .level         (level),
        .state         (state)
    );

    // pblrc edge history for rising-edge tick detection.
    always_ff @(posedge mclk) begin
        if (rst) pblrc_q <= 1'b0;
        else     pblrc_q <= pblrc;
    end

    // Stage 1: advance phase and freeze the per-sample controls on the tick.
    always_ff @(posedge mclk) begin
        if (rst) begin
            stg1_vld <= 1'b0;
            phase    <= '0;
            wave_q1  <= SAW;
            pw_q1    <= '0;
            vol_q1   <= '0;
        end else begin
            stg1_vld <= tick;
            if (tick) begin
                phase   <= phase + PHASE_BITS'(p_frequency);
                wave_q1 <= wave_t'(wave_sel);
                pw_q1   <= pulse_width;
                vol_q1  <= volume;
            end
        end
    end

    // Waveform shaping from the top 16 phase bits; XOR with 0x8000 is the -32768 offset.
    always_comb begin
        p        = phase[PHASE_BITS-1 -: 16];
        tri_t    = {p[14:0], 1'b0};
        wave_dat = '0;
        case (wave_q1)
            SAW:      wave_dat = $signed(p ^ 16'h8000);
            TRIANGLE: wave_dat = p[15] ? $signed(16'h7FFF - tri_t) : $signed(tri_t ^ 16'h8000);
            PULSE:    wave_dat = (p[15:8] < pw_q1) ? SAMPLE_MAX : SAMPLE_MIN;
            default:  wave_dat = '0;
        endcase
    end

    // Stage 2: register waveform alongside the envelope level it will be scaled by.
    always_ff @(posedge mclk) begin
        if (rst) begin
            stg2_vld <= 1'b0;
            wave_q2  <= '0;
            level_q2 <= '0;
            vol_q2   <= '0;
        end else begin
            stg2_vld <= stg1_vld;
            if (stg1_vld) begin
                wave_q2  <= wave_dat;
                level_q2 <= level;
                vol_q2   <= vol_q1;
            end
        end
    end

    // Full-width products, then arithmetic shifts (floor); both results fit 16 bits.
    always_comb begin
        prod1 = P1W'(wave_q2) * $signed(P1W'({1'b0, level_q2}));
        sh1   = prod1 >>> ENV_BITS;
        s1    = sh1[15:0];
        prod2 = P2W'(s1) * $signed(P2W'({1'b0, vol_q2}));
        sh2   = prod2 >>> VOLUME_BITS;
    end

    assign unused_ok = ^{sh1[P1W-1:16], sh2[P2W-1:16]};

    // Stage 3: output register and one-cycle valid pulse.
    always_ff @(posedge mclk) begin
        if (rst) begin
            valid           <= 1'b0;
            p_sample_buffer <= '0;
        end else begin
            valid <= stg2_vld;
            if (stg2_vld) p_sample_buffer <= sh2[15:0];
        end
    end

endmodule

// File: tb/tb_src_adsr_osc.sv
// Directed bench for src_adsr_osc: reset flush, SAW ramp, waveform/scaling table, ADSR walk.
// Latency: checks valid lands exactly 3 mclk after each pblrc rise.
// Backpressure: n/a; every wait is a fixed cycle count.
module tb_src_adsr_osc;
    import synth_pkg::*;

    logic               mclk = 1'b0;
    logic               rst = 1'b1;
    logic               pblrc = 1'b0;
    logic               gate = 1'b0;
    logic [1:0]         wave_sel = 2'd0;
    logic [23:0]        p_frequency = '0;
    logic [7:0]         pulse_width = '0;
    logic [15:0]        attack_rate = '0;
    logic [15:0]        decay_rate = '0;
    logic [15:0]        sustain_level = '0;
    logic [15:0]        release_rate = '0;
    logic [7:0]         volume = '0;
    logic signed [15:0] p_sample_buffer;
    logic               valid;
    logic [2:0]         env_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        gate;
        logic [1:0]  wave;
        logic [7:0]  pw;
        logic [23:0] freq;
        logic [7:0]  vol;
        int          exp_out;
        adsr_state_t exp_state;
    } vec_t;

    vec_t vecs[$];

    src_adsr_osc dut (
        .mclk            (mclk),
        .rst             (rst),
        .pblrc           (pblrc),
        .gate            (gate),
        .wave_sel        (wave_sel),
        .p_frequency     (p_frequency),
        .pulse_width     (pulse_width),
        .attack_rate     (attack_rate),
        .decay_rate      (decay_rate),
        .sustain_level   (sustain_level),
        .release_rate    (release_rate),
        .volume          (volume),
        .p_sample_buffer (p_sample_buffer),
        .valid           (valid),
        .env_state       (env_state)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Floor-scaled reference from the arithmetic definition of the output.
    function automatic int scale(input int w, input int lvl, input int vol);
        longint a;
        longint s;
        a = longint'(w) * longint'(lvl);
        s = a >>> 16;
        return int'((s * longint'(vol)) >>> 8);
    endfunction

    task automatic add(input logic g, input logic [1:0] w, input logic [7:0] pw,
                       input logic [23:0] f, input logic [7:0] v, input int eo,
                       input adsr_state_t es);
        vec_t t;
        t.gate = g; t.wave = w; t.pw = pw; t.freq = f; t.vol = v;
        t.exp_out = eo; t.exp_state = es;
        vecs.push_back(t);
    endtask

    // Called #1 after a posedge; raises pblrc for one cycle and watches 6 cycles.
    task automatic do_sample(output logic signed [15:0] s, output int lat, output int np);
        s = '0; lat = -1; np = 0;
        pblrc = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge mclk); #1;
            if (c == 1) pblrc = 1'b0;
            if (valid) begin
                np++;
                if (lat < 0) begin
                    lat = c;
                    s = p_sample_buffer;
                end
            end
        end
    endtask

    task automatic run_vecs(input string tag, input int lo, input int hi);
        logic signed [15:0] s;
        int lat, np;
        for (int i = lo; i <= hi; i++) begin
            gate        = vecs[i].gate;
            wave_sel    = vecs[i].wave;
            pulse_width = vecs[i].pw;
            p_frequency = vecs[i].freq;
            volume      = vecs[i].vol;
            do_sample(s, lat, np);
            check($sformatf("%s[%0d] sample", tag, i - lo), s, vecs[i].exp_out);
            check($sformatf("%s[%0d] env_state", tag, i - lo), env_state, vecs[i].exp_state);
            check($sformatf("%s[%0d] latency", tag, i - lo), lat, 3);
            check($sformatf("%s[%0d] pulses", tag, i - lo), np, 1);
        end
    endtask

    initial begin
        logic signed [15:0] s;
        int lat, np, nv, a_lo, a_hi, b_lo, b_hi;

        // Waveform / scaling / wrap table; level held at MAX in SUSTAIN, phase starts at 0.
        a_lo = 0;
        add(1, 2'd1, 8'd0,   24'h800000, 8'd128,  16383, SUSTAIN); // triangle peak
        add(1, 2'd1, 8'd0,   24'h000000, 8'd0,        0, SUSTAIN); // volume 0
        add(1, 2'd1, 8'd0,   24'h000000, 8'd255,  32638, SUSTAIN);
        add(1, 2'd2, 8'd0,   24'h000000, 8'd255, -32640, SUSTAIN); // pw 0 always low
        add(1, 2'd2, 8'd128, 24'h000000, 8'd255, -32640, SUSTAIN); // p=0x8000 at 50% edge
        add(1, 2'd2, 8'd129, 24'h000000, 8'd255,  32638, SUSTAIN);
        add(1, 2'd2, 8'd255, 24'h7F0000, 8'd255, -32640, SUSTAIN); // p[15:8]=255 low
        add(1, 2'd2, 8'd255, 24'h00FFFF, 8'd255, -32640, SUSTAIN); // phase all ones
        add(1, 2'd0, 8'd0,   24'h000001, 8'd128, -16384, SUSTAIN); // wrap to 0
        add(1, 2'd0, 8'd0,   24'hFFFFFF, 8'd255,  32638, SUSTAIN); // max increment
        add(1, 2'd0, 8'd0,   24'h000002, 8'd255, -32640, SUSTAIN); // wrap to 1
        add(1, 2'd1, 8'd0,   24'h3FFFFF, 8'd255,      0, SUSTAIN); // p=0x4000
        add(1, 2'd1, 8'd0,   24'h200000, 8'd255,  16319, SUSTAIN); // p=0x6000
        add(1, 2'd3, 8'd0,   24'h000000, 8'd255,      0, SUSTAIN); // silence
        add(1, 2'd0, 8'd0,   24'h000000, 8'd255,  -8160, SUSTAIN);
        add(1, 2'd1, 8'd0,   24'h000000, 8'd64,    4095, SUSTAIN);
        add(1, 2'd2, 8'd128, 24'h000000, 8'd255,  32638, SUSTAIN); // p[15:8]=0x60 high
        add(1, 2'd2, 8'd255, 24'h000000, 8'd255,  32638, SUSTAIN);
        a_hi = vecs.size() - 1;

        // ADSR walk: SAW at phase 0, volume 128 -> output = floor(floor(-level/2)/2).
        b_lo = vecs.size();
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,      0, ATTACK);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,  -4096, ATTACK);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,  -8192, ATTACK);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128, -12288, ATTACK);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128, -16384, DECAY);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128, -14336, DECAY);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128, -12288, DECAY);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128, -10240, DECAY);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,  -8192, SUSTAIN);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,  -8192, SUSTAIN);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -8192, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -7168, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -6144, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -5120, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -4096, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -3072, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -2048, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -1024, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,      0, IDLE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,      0, IDLE);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,      0, ATTACK);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,  -4096, ATTACK);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,  -8192, ATTACK);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -8192, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -7168, RELEASE);
        add(0, 2'd0, 8'd0, 24'h0, 8'd128,  -6144, RELEASE);
        add(1, 2'd0, 8'd0, 24'h0, 8'd128,  -6144, ATTACK);  // retrigger, no drop to 0
        add(1, 2'd0, 8'd0, 24'h0, 8'd128, -10240, ATTACK);
        b_hi = vecs.size() - 1;

        // Reset state.
        repeat (3) @(posedge mclk);
        #1;
        check("reset sample", p_sample_buffer, 0);
        check("reset valid", valid, 0);
        check("reset env_state", env_state, IDLE);

        // Reach a non-trivial state, then reset while a sample is in flight.
        rst = 1'b0;
        gate = 1'b1; attack_rate = 16'hFFFF; sustain_level = 16'hFFFF;
        wave_sel = 2'd0; p_frequency = '0; volume = 8'd255;
        do_sample(s, lat, np);
        check("pre-reset env_state 1", env_state, ATTACK);
        do_sample(s, lat, np);
        check("pre-reset sample", s, -32640);
        check("pre-reset env_state 2", env_state, DECAY);

        pblrc = 1'b1;
        @(posedge mclk); #1;
        pblrc = 1'b0;
        rst = 1'b1;
        nv = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge mclk); #1;
            if (valid) nv++;
            if (c == 2) begin
                check("flush sample", p_sample_buffer, 0);
                check("flush env_state", env_state, IDLE);
                rst = 1'b0;
            end
        end
        check("flush valid pulses", nv, 0);

        // SAW ramp at level MAX: three ticks of warm-up with frozen phase.
        decay_rate = '0; release_rate = '0;
        for (int i = 0; i < 3; i++) do_sample(s, lat, np);
        check("warmup env_state", env_state, SUSTAIN);
        p_frequency = 24'd262144;
        for (int n = 1; n <= 64; n++) begin
            do_sample(s, lat, np);
            check($sformatf("saw[%0d] sample", n), s, scale((n % 64) * 1024 - 32768, 65535, 255));
            check($sformatf("saw[%0d] latency", n), lat, 3);
            check($sformatf("saw[%0d] pulses", n), np, 1);
        end

        run_vecs("wave", a_lo, a_hi);

        // Fresh envelope and phase for the ADSR walk.
        rst = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        rst = 1'b0;
        attack_rate = 16'd16384; decay_rate = 16'd8192;
        sustain_level = 16'd32768; release_rate = 16'd4096;
        run_vecs("adsr", b_lo, b_hi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
